// File: rtl/zint_gen_if.sv
// rtl/zint_gen_if.sv - raster strobes, config write port and INT outputs of zint_gen
interface zint_gen_if;
    logic       frame_start;
    logic       line_start;
    logic       zpos;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       int_start;
    logic       int_pending;

    modport master (
        output frame_start, line_start, zpos, cfg_we, cfg_addr, cfg_data,
        input  int_start, int_pending
    );

    modport slave (
        input  frame_start, line_start, zpos, cfg_we, cfg_addr, cfg_data,
        output int_start, int_pending
    );
endinterface

// File: rtl/zint_gen.sv
// rtl/zint_gen.sv - raster-position INT start strobe, released on a Z80 clock rising phase
// Optional per-line INT mode: ZINT_LINE_INT_EN
module zint_gen #(
    parameter int HCNT_W = 9,
    parameter int VCNT_W = 9
) (
    input  logic      fclk,
    input  logic      rst_n,
    zint_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FIRE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic [8:0]        r_int_line;
    logic [7:0]        r_int_hpos;
    logic              r_frame_int_en;
    logic              w_line_int_en;
    logic              w_hmatch;
    logic              w_vmatch;
    logic              w_match;
    logic              w_rearm;

    // Counters saturate so a missing frame/line strobe can never wrap into a false match
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (bus.frame_start) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (bus.line_start) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == '1) ? r_vcnt : r_vcnt + VCNT_W'(1);
        end else begin
            r_hcnt <= (r_hcnt == '1) ? r_hcnt : r_hcnt + HCNT_W'(1);
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_line     <= '0;
            r_int_hpos     <= '0;
            r_frame_int_en <= 1'b1;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0: r_int_line[7:0] <= bus.cfg_data;
                2'd1: begin
                    r_int_line[8]  <= bus.cfg_data[0];
                    r_frame_int_en <= bus.cfg_data[7];
                end
                2'd2:    r_int_hpos <= bus.cfg_data;
                default: ;
            endcase
        end
    end

`ifdef ZINT_LINE_INT_EN
    logic r_line_int_en;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_int_en <= 1'b0;
        end else if (bus.cfg_we && bus.cfg_addr == 2'd1) begin
            r_line_int_en <= bus.cfg_data[6];
        end
    end

    assign w_line_int_en = r_line_int_en;
`else
    assign w_line_int_en = 1'b0;
`endif

    // int_hpos[8] is architecturally zero, hence the zero-extension of the 8-bit register
    assign w_hmatch = (r_hcnt == HCNT_W'(r_int_hpos));
    assign w_vmatch = (r_vcnt == VCNT_W'(r_int_line));
    assign w_match  = w_hmatch && ((r_frame_int_en && w_vmatch) || w_line_int_en);
    assign w_rearm  = bus.frame_start || (bus.line_start && w_line_int_en);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Once PEND is entered the INT is always delivered; frame_start only rearms from DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_match) w_state_nxt = S_PEND;
            S_PEND:  if (bus.zpos) w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = S_DONE;
            S_DONE:  if (w_rearm) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.int_start   = (r_state == S_FIRE);
    assign bus.int_pending = (r_state == S_PEND);
endmodule

// File: tb/tb_zint_gen.sv
// tb/tb_zint_gen.sv - directed-vector bench for zint_gen
module tb_zint_gen;
    logic fclk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   st_n_start;
    int   st_first_start;
    int   st_last_start;
    int   st_n_pend;
    int   st_first_pend;

    zint_gen_if bus ();

    zint_gen #(.HCNT_W(9), .VCNT_W(9)) dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 fclk = ~fclk;

    task automatic tick;
        @(posedge fclk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.zpos        = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 2'd0;
        bus.cfg_data    = 8'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.int_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_int_start: got %b expected 0", bus.int_start);
        end
        n_tests++;
        if (bus.int_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_int_pending: got %b expected 0", bus.int_pending);
        end
        rst_n = 1'b1;
    endtask

    // zpos held high so any INT raised by the post-reset counter state drains to DONE
    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        bus.zpos     = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg_settle;
        bus.zpos = 1'b1;
        repeat (3) tick();
        idle_inputs();
    endtask

    task automatic drive(input int ncyc, input int line_len, input int frame_len,
                         input int zper, input int zph, input int zstart,
                         input int wr_cyc, input logic [1:0] wr_addr, input logic [7:0] wr_data);
        st_n_start     = 0;
        st_first_start = -1;
        st_last_start  = -1;
        st_n_pend      = 0;
        st_first_pend  = -1;
        for (int c = 0; c < ncyc; c++) begin
            bus.frame_start = (c % frame_len == 0);
            bus.line_start  = (c % line_len == 0);
            bus.zpos        = (c >= zstart) && (c % zper == zph);
            bus.cfg_we      = (c == wr_cyc);
            bus.cfg_addr    = wr_addr;
            bus.cfg_data    = wr_data;
            if (bus.int_start === 1'b1) begin
                st_n_start++;
                if (st_first_start < 0) st_first_start = c;
                st_last_start = c;
            end
            if (bus.int_pending === 1'b1) begin
                st_n_pend++;
                if (st_first_pend < 0) st_first_pend = c;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        n_tests++;
        if (bus.int_start !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_int_start: got %b expected 0", bus.int_start);
        end
    endtask

    // frame 0: counters 0 at cycle 0; frame 1 starts at 1344, matches at 1345, zpos at 1349
    task automatic test_first_frame;
        do_reset();
        drive(2688, 448, 1344, 4, 1, 0, -1, 2'd0, 8'd0);
        n_tests++;
        if (st_first_pend !== 1) begin
            n_fail++;
            $display("FAIL first_frame_pend_cycle: got %0d expected 1", st_first_pend);
        end
        n_tests++;
        if (st_first_start !== 2) begin
            n_fail++;
            $display("FAIL first_frame_start_cycle: got %0d expected 2", st_first_start);
        end
        n_tests++;
        if (st_n_start !== 2) begin
            n_fail++;
            $display("FAIL first_frame_pulse_count: got %0d expected 2", st_n_start);
        end
        n_tests++;
        if (st_last_start !== 1350) begin
            n_fail++;
            $display("FAIL second_frame_start_cycle: got %0d expected 1350", st_last_start);
        end
        n_tests++;
        if (st_n_pend !== 5) begin
            n_fail++;
            $display("FAIL first_frame_pend_cycles: got %0d expected 5", st_n_pend);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.zpos = 1'b0;
        tick();
        n_tests++;
        if (bus.int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pend_before: got %b expected 1", bus.int_pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.int_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pend_dropped: got %b expected 0", bus.int_pending);
        end
        do_reset();
        bus.zpos = 1'b0;
        tick();
        bus.zpos = 1'b1;
        tick();
        n_tests++;
        if (bus.int_start !== 1'b1) begin
            n_fail++;
            $display("FAIL async_fire_before: got %b expected 1", bus.int_start);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.int_start !== 1'b0) begin
            n_fail++;
            $display("FAIL async_fire_dropped: got %b expected 0", bus.int_start);
        end
    endtask

    // int_line 0x120, hpos 0x10, 32-cycle lines: match at 288*32+17 = 9233; enable cleared mid-PEND
    task automatic test_late_zpos;
        do_reset();
        cfg_write(2'd0, 8'h20);
        cfg_write(2'd1, 8'h81);
        cfg_write(2'd2, 8'h10);
        cfg_settle();
        drive(9600, 32, 100000, 8, 5, 0, 9235, 2'd1, 8'h01);
        n_tests++;
        if (st_first_pend !== 9234) begin
            n_fail++;
            $display("FAIL late_zpos_pend_cycle: got %0d expected 9234", st_first_pend);
        end
        n_tests++;
        if (st_n_pend !== 4) begin
            n_fail++;
            $display("FAIL late_zpos_pend_cycles: got %0d expected 4", st_n_pend);
        end
        n_tests++;
        if (st_first_start !== 9238) begin
            n_fail++;
            $display("FAIL late_zpos_start_cycle: got %0d expected 9238", st_first_start);
        end
        n_tests++;
        if (st_n_start !== 1) begin
            n_fail++;
            $display("FAIL late_zpos_pulse_count: got %0d expected 1", st_n_start);
        end
    endtask

    task automatic test_frame_int_disable;
        do_reset();
        cfg_write(2'd1, 8'h00);
        cfg_settle();
        drive(2688, 448, 1344, 4, 1, 0, -1, 2'd0, 8'd0);
        n_tests++;
        if (st_n_start !== 0) begin
            n_fail++;
            $display("FAIL disable_pulse_count: got %0d expected 0", st_n_start);
        end
        n_tests++;
        if (st_n_pend !== 0) begin
            n_fail++;
            $display("FAIL disable_pend_cycles: got %0d expected 0", st_n_pend);
        end
    endtask

    task automatic test_hpos_beyond_line;
        do_reset();
        cfg_write(2'd2, 8'hFF);
        cfg_settle();
        drive(1600, 200, 800, 4, 0, 0, -1, 2'd0, 8'd0);
        n_tests++;
        if (st_n_start !== 0) begin
            n_fail++;
            $display("FAIL beyond_line_pulse_count: got %0d expected 0", st_n_start);
        end
        n_tests++;
        if (st_n_pend !== 0) begin
            n_fail++;
            $display("FAIL beyond_line_pend_cycles: got %0d expected 0", st_n_pend);
        end
    endtask

    // hcnt passes 5 while disabled; enabling later would only match if hcnt wrapped past 511
    task automatic test_counter_saturation;
        do_reset();
        cfg_write(2'd2, 8'h05);
        cfg_write(2'd1, 8'h00);
        cfg_settle();
        drive(1200, 100000, 100000, 1, 0, 0, 20, 2'd1, 8'h80);
        n_tests++;
        if (st_n_start !== 0) begin
            n_fail++;
            $display("FAIL saturation_pulse_count: got %0d expected 0", st_n_start);
        end
    endtask

    // 40-cycle frames: match 17, frame_start 40 during PEND, zpos only from 42; next frame 80 rearms
    task automatic test_frame_start_in_pend;
        do_reset();
        cfg_write(2'd2, 8'h10);
        cfg_settle();
        drive(120, 20, 40, 4, 2, 42, -1, 2'd0, 8'd0);
        n_tests++;
        if (st_first_pend !== 18) begin
            n_fail++;
            $display("FAIL fs_in_pend_pend_cycle: got %0d expected 18", st_first_pend);
        end
        n_tests++;
        if (st_first_start !== 43) begin
            n_fail++;
            $display("FAIL fs_in_pend_start_cycle: got %0d expected 43", st_first_start);
        end
        n_tests++;
        if (st_n_start !== 2) begin
            n_fail++;
            $display("FAIL fs_in_pend_pulse_count: got %0d expected 2", st_n_start);
        end
        n_tests++;
        if (st_last_start !== 99) begin
            n_fail++;
            $display("FAIL fs_in_pend_rearm_cycle: got %0d expected 99", st_last_start);
        end
        n_tests++;
        if (st_n_pend !== 26) begin
            n_fail++;
            $display("FAIL fs_in_pend_pend_cycles: got %0d expected 26", st_n_pend);
        end
    endtask

    task automatic test_line_int;
        do_reset();
        cfg_write(2'd2, 8'h05);
        cfg_write(2'd1, 8'h40);
        cfg_settle();
        drive(160, 40, 100000, 4, 0, 0, -1, 2'd0, 8'd0);
`ifdef ZINT_LINE_INT_EN
        n_tests++;
        if (st_n_start !== 4) begin
            n_fail++;
            $display("FAIL line_int_pulse_count: got %0d expected 4", st_n_start);
        end
        n_tests++;
        if (st_first_start !== 9) begin
            n_fail++;
            $display("FAIL line_int_first_cycle: got %0d expected 9", st_first_start);
        end
        n_tests++;
        if (st_last_start !== 129) begin
            n_fail++;
            $display("FAIL line_int_last_cycle: got %0d expected 129", st_last_start);
        end
`else
        n_tests++;
        if (st_n_start !== 0) begin
            n_fail++;
            $display("FAIL line_int_off_pulse_count: got %0d expected 0", st_n_start);
        end
        n_tests++;
        if (st_n_pend !== 0) begin
            n_fail++;
            $display("FAIL line_int_off_pend_cycles: got %0d expected 0", st_n_pend);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_first_frame();
        test_async_reset();
        test_late_zpos();
        test_frame_int_disable();
        test_hpos_beyond_line();
        test_counter_saturation();
        test_frame_start_in_pend();
        test_line_int();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
